// File: rtl/file_mem_ctrl.sv
// file_mem_ctrl: sequences the initial table load from a file word stream
// (padding with FILL_VALUE after end-of-file), then round-robin arbitrates
// single-port memory reads between two requesters.
module file_mem_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ROM_DEPTH  = 16,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  src_valid_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic                  src_eof_i,
  output logic                  src_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [1:0]            req_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  load_done_o,
  output logic [ADDR_WIDTH:0]   fill_count_o
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   fill_count_q, fill_count_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  write;
  logic [DATA_WIDTH-1:0] write_word;
  logic                  src_ready;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] read_addr;

  // Load sequencing, fill padding, and read arbitration (all combinational).
  // Strobes are qualified with rst_ni so the memory bus is quiet while reset
  // is held, even if the stream source keeps asserting src_valid.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_count_d = fill_count_q;
    last_gnt_d   = last_gnt_q;
    write        = 1'b0;
    write_word   = '0;
    src_ready    = 1'b0;
    gnt          = 2'b00;
    read_addr    = '0;
    case (state_q)
      ST_LOAD: begin
        src_ready = ~src_eof_i;
        if (src_eof_i) begin
          // EOF wins over a simultaneous valid word; that word is dropped.
          state_d = ST_FILL;
        end else if (src_valid_i) begin
          write      = 1'b1;
          write_word = src_data_i;
        end
      end
      ST_FILL: begin
        write        = 1'b1;
        write_word   = FILL_VALUE;
        fill_count_d = fill_count_q + (ADDR_WIDTH+1)'(1);
      end
      ST_READY: begin
        // Contention goes to the requester not served last.
        if (req_i == 2'b11) gnt = last_gnt_q ? 2'b01 : 2'b10;
        else                gnt = req_i;
        if (gnt[0]) begin
          read_addr  = addr0_i;
          last_gnt_d = 1'b0;
        end else if (gnt[1]) begin
          read_addr  = addr1_i;
          last_gnt_d = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // The write to the last address ends the load; the pointer parks there.
    if (write) begin
      if (wr_ptr_q == LAST_ADDR) state_d  = ST_READY;
      else                       wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
  end

  assign src_ready_o  = rst_ni & src_ready;
  assign mem_we_o     = rst_ni & write;
  assign mem_addr_o   = (rst_ni & write) ? wr_ptr_q : read_addr;
  assign mem_wdata_o  = (rst_ni & write) ? write_word : '0;
  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = (rvalid_q != 2'b00) ? mem_rdata_i : rdata_q;
  assign load_done_o  = (state_q == ST_READY);
  assign fill_count_o = fill_count_q;

  // Controller state: FSM, write pointer, fill counter, arbiter history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      fill_count_q <= '0;
      last_gnt_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_count_q <= fill_count_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  // Read return: rvalid one cycle after grant; rdata holds the last word read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      if (rvalid_q != 2'b00) rdata_q <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_file_mem_ctrl.sv
// Testbench for file_mem_ctrl: behavioural memory macro, load-image model
// built from the stream/EOF rules, and a round-robin read model.
module tb_file_mem_ctrl;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] FILL = 4'b0001;

  logic          clk, rst_ni;
  logic          src_valid, src_eof, src_ready;
  logic [DW-1:0] src_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    req, gnt, rvalid;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rdata;
  logic          load_done;
  logic [AW:0]   fill_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tb_mem  [DEPTH];
  logic [DW-1:0] exp_img [DEPTH];
  bit            exp_last;
  logic [DW-1:0] hold_rd;

  file_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_DEPTH(DEPTH), .FILL_VALUE(FILL)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_eof_i(src_eof), .src_ready_o(src_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .req_i(req), .addr0_i(addr0), .addr1_i(addr1), .gnt_o(gnt),
    .rvalid_o(rvalid), .rdata_o(rdata), .load_done_o(load_done), .fill_count_o(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory macro with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic idle_inputs();
    src_valid = 1'b0; src_eof = 1'b0; src_data = '0;
    req = 2'b00; addr0 = '0; addr1 = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0;
    idle_inputs();
    exp_last = 1'b1;
    hold_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0;
    src_valid = 1'b1; src_eof = 1'b0; src_data = 4'hF; req = 2'b11;
    exp_last = 1'b1; hold_rd = '0;
    #1;
    checks++;
    if ({src_ready, mem_we, mem_addr, mem_wdata, gnt, rvalid, rdata, load_done, fill_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b we=%b addr=%0d wd=%0d gnt=%b rv=%b rd=%0d done=%b fc=%0d, need all 0",
               src_ready, mem_we, mem_addr, mem_wdata, gnt, rvalid, rdata, load_done, fill_count);
    end
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst_ni = 1'b1;
    #2;
    checks++;
    if (src_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b need 1", src_ready);
    end
  endtask

  // Streams n words (random stalls) then optionally EOF; checks write
  // sequence, memory image, fill count, load time and READY outputs.
  task automatic do_load(input int n, input bit use_eof, input bit valid_on_eof,
                         input bit rand_data, input logic [DW-1:0] base);
    logic [DW-1:0] words[$];
    logic [AW-1:0] obs_a[$];
    logic [DW-1:0] obs_d[$];
    int accepted = 0, stalls = 0, cyc = 0;
    int exp_cyc, exp_fill;
    for (int i = 0; i < n; i++) words.push_back(rand_data ? DW'($urandom) : DW'(base + i));
    for (int i = 0; i < DEPTH; i++) exp_img[i] = (i < n) ? words[i] : FILL;
    while (cyc < 300) begin
      @(negedge clk);
      if (load_done) break;
      if (accepted < n) begin
        src_eof = 1'b0; src_valid = ($urandom % 4) != 0; src_data = words[accepted];
      end else if (use_eof) begin
        src_eof = 1'b1; src_valid = valid_on_eof; src_data = 4'd7;
      end else begin
        src_eof = 1'b0; src_valid = 1'b1; src_data = DW'($urandom);
      end
      req = 2'($urandom); addr0 = AW'($urandom); addr1 = AW'($urandom);
      #2;
      cyc++;
      checks++;
      if (src_ready !== ~src_eof) begin
        errors++;
        $display("FAIL load_src_ready: cycle %0d got %b need %b", cyc, src_ready, ~src_eof);
      end
      checks++;
      if (gnt !== 2'b00) begin
        errors++;
        $display("FAIL load_gnt: cycle %0d got %b need 00", cyc, gnt);
      end
      if (mem_we === 1'b1) begin
        obs_a.push_back(mem_addr); obs_d.push_back(mem_wdata);
        $display("write addr=%0d data=%h", mem_addr, mem_wdata);
      end
      if (accepted < n) begin
        if (src_valid) accepted++;
        else stalls++;
      end
    end
    checks++;
    if (!load_done) begin
      errors++;
      $display("FAIL load_timeout: load_done got %b need 1 within 300 cycles", load_done);
    end
    exp_cyc  = DEPTH + stalls + ((use_eof && n < DEPTH) ? 1 : 0);
    exp_fill = (use_eof && n < DEPTH) ? DEPTH - n : 0;
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL load_time: got %0d cycles need %0d", cyc, exp_cyc);
    end
    checks++;
    if (fill_count !== (AW+1)'(exp_fill)) begin
      errors++;
      $display("FAIL fill_count: got %0d need %0d", fill_count, exp_fill);
    end
    checks++;
    if (src_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL ready_outputs: src_ready=%b mem_we=%b need 0 0", src_ready, mem_we);
    end
    checks++;
    if (obs_a.size() != DEPTH) begin
      errors++;
      $display("FAIL write_count: got %0d need %0d", obs_a.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== AW'(i) || obs_d[i] !== exp_img[i]) begin
        errors++;
        $display("FAIL write_%0d: got addr=%0d data=%h need addr=%0d data=%h",
                 i, obs_a[i], obs_d[i], i, exp_img[i]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (tb_mem[i] !== exp_img[i]) begin
        errors++;
        $display("FAIL mem_%0d: got %h need %h", i, tb_mem[i], exp_img[i]);
      end
    end
    idle_inputs();
  endtask

  // Requesters raise req with probability pct and hold until granted.
  task automatic test_arbiter(input int ncyc, input int pct, input bit fixed);
    bit pend[2];
    logic [AW-1:0] paddr[2];
    logic [1:0] egnt;
    logic [1:0] exp_rv = 2'b00;
    logic [DW-1:0] exp_rd = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    paddr[0] = '0; paddr[1] = '0;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (!pend[i] && ($urandom % 100) < pct) begin
          pend[i] = 1'b1;
          paddr[i] = fixed ? ((i == 0) ? AW'(2) : AW'(9)) : AW'($urandom);
        end
      if (c == ncyc) begin pend[0] = 1'b0; pend[1] = 1'b0; end
      req = {pend[1], pend[0]}; addr0 = paddr[0]; addr1 = paddr[1];
      #2;
      if (pend[0] && pend[1]) egnt = exp_last ? 2'b01 : 2'b10;
      else                    egnt = {pend[1], pend[0]};
      checks++;
      if (gnt !== egnt) begin
        errors++;
        $display("FAIL arb_gnt: cycle %0d req=%b got %b need %b", c, req, gnt, egnt);
      end
      checks++;
      if (rvalid !== exp_rv) begin
        errors++;
        $display("FAIL arb_rvalid: cycle %0d got %b need %b", c, rvalid, exp_rv);
      end
      if (exp_rv != 2'b00) hold_rd = exp_rd;
      checks++;
      if (rdata !== hold_rd) begin
        errors++;
        $display("FAIL arb_rdata: cycle %0d got %h need %h", c, rdata, hold_rd);
      end
      exp_rv = 2'b00;
      if (egnt[0]) begin
        exp_last = 1'b0; pend[0] = 1'b0; exp_rv = 2'b01; exp_rd = exp_img[paddr[0]];
        $display("read req0 addr=%0d expect=%h", paddr[0], exp_rd);
      end else if (egnt[1]) begin
        exp_last = 1'b1; pend[1] = 1'b0; exp_rv = 2'b10; exp_rd = exp_img[paddr[1]];
        $display("read req1 addr=%0d expect=%h", paddr[1], exp_rd);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_load();
    int acc = 0;
    for (int c = 0; c < 40 && acc < 7; c++) begin
      @(negedge clk);
      src_valid = 1'b1; src_eof = 1'b0; src_data = DW'($urandom);
      #2;
      if (src_valid && src_ready) acc++;
    end
    @(posedge clk); #1;
    rst_ni = 1'b0;
    exp_last = 1'b1; hold_rd = '0;
    #1;
    checks++;
    if ({src_ready, mem_we, mem_addr, mem_wdata, gnt, rvalid, rdata, load_done, fill_count} !== '0) begin
      errors++;
      $display("FAIL midload_reset: got rdy=%b we=%b addr=%0d wd=%0d gnt=%b rv=%b rd=%0d done=%b fc=%0d, need all 0",
               src_ready, mem_we, mem_addr, mem_wdata, gnt, rvalid, rdata, load_done, fill_count);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset_during_rvalid();
    @(negedge clk);
    req = 2'b01; addr0 = 4'd3;
    @(posedge clk); #1;
    req = 2'b00;
    checks++;
    if (rvalid !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_rvalid: got %b need 01", rvalid);
    end
    rst_ni = 1'b0;
    exp_last = 1'b1; hold_rd = '0;
    #1;
    checks++;
    if (rvalid !== 2'b00 || rdata !== '0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_reset: got rv=%b rd=%h done=%b need 00 0 0", rvalid, rdata, load_done);
    end
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b1;
    idle_inputs();
    exp_last = 1'b1;
    hold_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin tb_mem[i] = '0; exp_img[i] = '0; end
    #2;
    test_reset();
    do_load(16, 1'b0, 1'b0, 1'b0, 4'h0);           // full stream 0..15
    test_arbiter(4, 100, 1'b1);                     // strict alternation 2/9
    test_arbiter(150, 60, 1'b0);
    apply_reset();
    do_load(5, 1'b1, 1'b0, 1'b0, 4'hA);            // A..E then EOF
    test_arbiter(100, 40, 1'b0);
    apply_reset();
    do_load(0, 1'b1, 1'b0, 1'b0, 4'h0);            // EOF from the start
    test_arbiter(40, 80, 1'b0);
    apply_reset();
    do_load(3, 1'b1, 1'b1, 1'b0, 4'h4);            // valid+EOF same cycle at addr 3
    apply_reset();
    do_load(int'($urandom_range(1, 15)), 1'b1, 1'b1, 1'b1, 4'h0);
    test_arbiter(100, 50, 1'b0);
    apply_reset();
    test_reset_mid_load();
    do_load(16, 1'b0, 1'b0, 1'b1, 4'h0);
    test_arbiter(30, 70, 1'b0);
    test_reset_during_rvalid();
    do_load(9, 1'b1, 1'b0, 1'b1, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
